prog_loader: RTL and testbench

- Sits between the cpu memory port and the single-port halfword memory.
- After reset it holds the cpu in reset and owns the memory port. It receives a program as a byte stream over a valid/ready handshake, packs the bytes into halfwords and writes them to memory from address 0.
- It then releases the cpu and passes the cpu memory port straight through to memory.

---
 rtl/prog_loader_if.sv | 39 +++
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - loader byte stream, cpu memory port and memory port bundle
interface prog_loader_if #(
    parameter int MEM_DEPTH = 2**12
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2);

    logic                  i_ld_valid;
    logic [7:0]            i_ld_data;
    logic                  o_ld_ready;
    logic                  o_cpu_rst;
    logic                  o_done;
    logic                  o_err;
    logic [0:1][7:0]       i_cpu_mem_di;
    logic [ADDR_WIDTH-1:0] i_cpu_mem_addr;
    logic                  i_cpu_mem_en;
    logic                  i_cpu_mem_rd_en;
    logic [0:1]            i_cpu_mem_wr_en;
    logic [0:1][7:0]       o_cpu_mem_do;
    logic [0:1][7:0]       o_mem_di;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_en;
    logic                  o_mem_rd_en;
    logic [0:1]            o_mem_wr_en;
    logic [0:1][7:0]       i_mem_do;

    modport slave (
        input  i_ld_valid, i_ld_data, i_cpu_mem_di, i_cpu_mem_addr, i_cpu_mem_en,
               i_cpu_mem_rd_en, i_cpu_mem_wr_en, i_mem_do,
        output o_ld_ready, o_cpu_rst, o_done, o_err, o_cpu_mem_do, o_mem_di,
               o_mem_addr, o_mem_en, o_mem_rd_en, o_mem_wr_en
    );

    modport master (
        output i_ld_valid, i_ld_data, i_cpu_mem_di, i_cpu_mem_addr, i_cpu_mem_en,
               i_cpu_mem_rd_en, i_cpu_mem_wr_en, i_mem_do,
        input  o_ld_ready, o_cpu_rst, o_done, o_err, o_cpu_mem_do, o_mem_di,
               o_mem_addr, o_mem_en, o_mem_rd_en, o_mem_wr_en
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: streams a program into halfword memory, then hands the port to the cpu
module prog_loader #(
    parameter int MEM_DEPTH = 2**12
) (
    input logic         clk,
    input logic         rst,
    prog_loader_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN, ERR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] count;
    logic [15:0]           n;
    logic [7:0]            b0;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [0:1][7:0]       ld_di;
    logic                  ld_en;
    logic [0:1]            ld_wr_en;
    logic                  cpu_rst_q, done_q, err_q;
    logic                  ready, hs, last;
    logic [15:0]           n_in;

    assign n_in = {n[15:8], bus.i_ld_data};
    assign last = (32'(count) + 32'd1) == 32'(n);
    assign hs   = bus.i_ld_valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LEN_HI;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            LEN_HI: begin
                ready = 1'b1;
                if (hs) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                ready = 1'b1;
                if (hs) begin
                    if (n_in == 16'd0)                    state_nxt = RUN;
                    else if (32'(n_in) > 32'(MEM_DEPTH)) state_nxt = ERR;
                    else                                  state_nxt = DATA_HI;
                end
            end
            DATA_HI: begin
                ready = 1'b1;
                if (hs) state_nxt = DATA_LO;
            end
            DATA_LO: begin
                ready = 1'b1;
                if (hs) state_nxt = WRITE;
            end
            WRITE:   state_nxt = last ? RUN : DATA_HI;
            default: state_nxt = state;
        endcase
    end

    // Write strobes are loaded on the DATA_LO handshake so they are high exactly while in WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            n         <= '0;
            b0        <= '0;
            ld_addr   <= '0;
            ld_di     <= '0;
            ld_en     <= 1'b0;
            ld_wr_en  <= 2'b00;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ld_addr  <= '0;
            ld_di    <= '0;
            ld_en    <= 1'b0;
            ld_wr_en <= 2'b00;
            case (state)
                LEN_HI:  if (hs) n[15:8] <= bus.i_ld_data;
                LEN_LO:  if (hs) n[7:0] <= bus.i_ld_data;
                DATA_HI: if (hs) b0 <= bus.i_ld_data;
                DATA_LO: if (hs) begin
                    ld_en    <= 1'b1;
                    ld_wr_en <= 2'b11;
                    ld_addr  <= count << 1;
                    ld_di    <= {b0, bus.i_ld_data};
                end
                WRITE:   count <= count + 1'b1;
                default: ;
            endcase
            if (state_nxt == RUN && state != RUN) begin
                cpu_rst_q <= 1'b0;
                done_q    <= 1'b1;
            end
            if (state_nxt == ERR) err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.o_ld_ready   = ready;
        bus.o_cpu_rst    = cpu_rst_q;
        bus.o_done       = done_q;
        bus.o_err        = err_q;
        bus.o_cpu_mem_do = bus.i_mem_do;
        bus.o_mem_di     = ld_di;
        bus.o_mem_addr   = ld_addr;
        bus.o_mem_en     = ld_en;
        bus.o_mem_rd_en  = 1'b0;
        bus.o_mem_wr_en  = ld_wr_en;
        if (state == RUN) begin
            bus.o_mem_di    = bus.i_cpu_mem_di;
            bus.o_mem_addr  = bus.i_cpu_mem_addr;
            bus.o_mem_en    = bus.i_cpu_mem_en;
            bus.o_mem_rd_en = bus.i_cpu_mem_rd_en;
            bus.o_mem_wr_en = bus.i_cpu_mem_wr_en;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ld_en_cnt = 0;
    int   ready_in_write = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_di[$];
    int          wr_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    prog_loader_if #(.MEM_DEPTH(4096)) bus();
    prog_loader #(.MEM_DEPTH(4096)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Loader-owned memory cycles are those while the cpu is still held in reset.
    always @(negedge clk) begin
        if (rst && bus.o_mem_en && bus.o_cpu_rst) begin
            ld_en_cnt++;
            if (bus.o_ld_ready) ready_in_write++;
            if (bus.o_mem_wr_en == 2'b11) begin
                wr_addr.push_back(32'(bus.o_mem_addr));
                wr_di.push_back(32'(bus.o_mem_di));
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        bus.i_ld_data  = b;
        bus.i_ld_valid = 1'b1;
        t = 0;
        while (!bus.o_ld_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("ld_ready_wait", 32'(bus.o_ld_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        bus.i_ld_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.i_ld_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic check_two_writes(input string tag, input int base);
        check({tag, "_nwr"}, 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() - base == 2) begin
            check({tag, "_addr0"}, wr_addr[base], 32'h0);
            check({tag, "_di0"}, wr_di[base], 32'h1234);
            check({tag, "_addr1"}, wr_addr[base+1], 32'h2);
            check({tag, "_di1"}, wr_di[base+1], 32'hABCD);
        end
    endtask

    initial begin
        int base, en0, rw0;
        bus.i_ld_valid = 1'b0; bus.i_ld_data = '0;
        bus.i_cpu_mem_di = '0; bus.i_cpu_mem_addr = '0; bus.i_cpu_mem_en = 1'b0;
        bus.i_cpu_mem_rd_en = 1'b0; bus.i_cpu_mem_wr_en = 2'b00; bus.i_mem_do = '0;
        #22;
        check("rst_cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        check("rst_ready", 32'(bus.o_ld_ready), 32'd1);
        check("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
        check("rst_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
        check("rst_addr", 32'(bus.o_mem_addr), 32'd0);
        check("rst_di", 32'(bus.o_mem_di), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // continuous stream, two halfwords
        base = wr_addr.size();
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        bus.i_ld_valid = 1'b0;
        check("w2_mem_en", 32'(bus.o_mem_en), 32'd1);
        check("w2_addr", 32'(bus.o_mem_addr), 32'h2);
        check("w2_di", 32'(bus.o_mem_di), 32'hABCD);
        check("w2_ready", 32'(bus.o_ld_ready), 32'd0);
        check("w2_done_early", 32'(bus.o_done), 32'd0);
        @(posedge clk); #1;
        check("c_done", 32'(bus.o_done), 32'd1);
        check("c_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
        check_two_writes("c", base);
        if (wr_cyc.size() - base == 2)
            check("c_hw_cycles", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd3);

        // cpu pass-through in RUN
        bus.i_ld_valid = 1'b1;
        bus.i_cpu_mem_addr = 13'h0010; bus.i_cpu_mem_en = 1'b1; bus.i_cpu_mem_rd_en = 1'b1;
        bus.i_cpu_mem_wr_en = 2'b00; bus.i_mem_do = {8'h5A, 8'hA5}; bus.i_cpu_mem_di = {8'h11, 8'h22};
        #1;
        check("run_addr", 32'(bus.o_mem_addr), 32'h10);
        check("run_en", 32'(bus.o_mem_en), 32'd1);
        check("run_rd_en", 32'(bus.o_mem_rd_en), 32'd1);
        check("run_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
        check("run_di", 32'(bus.o_mem_di), 32'h1122);
        check("run_do", 32'(bus.o_cpu_mem_do), 32'h5AA5);
        check("run_ready", 32'(bus.o_ld_ready), 32'd0);
        bus.i_cpu_mem_wr_en = 2'b10; bus.i_cpu_mem_addr = 13'h1FFE;
        #1;
        check("run_wr_en2", 32'(bus.o_mem_wr_en), 32'h2);
        check("run_addr2", 32'(bus.o_mem_addr), 32'h1FFE);
        bus.i_cpu_mem_addr = '0; bus.i_cpu_mem_en = 1'b0; bus.i_cpu_mem_rd_en = 1'b0;
        bus.i_cpu_mem_wr_en = 2'b00; bus.i_cpu_mem_di = '0;
        do_reset();

        // gapped valid
        base = wr_addr.size();
        rw0 = ready_in_write;
        send_gap(8'h00); send_gap(8'h02); send_gap(8'h12); send_gap(8'h34); send_gap(8'hAB); send_gap(8'hCD);
        check("g_done", 32'(bus.o_done), 32'd1);
        check_two_writes("g", base);
        check("g_ready_in_write", 32'(ready_in_write - rw0), 32'd0);
        do_reset();

        // zero length
        en0 = ld_en_cnt;
        send(8'h00); send(8'h00);
        bus.i_ld_valid = 1'b0;
        check("z_done", 32'(bus.o_done), 32'd1);
        check("z_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("z_no_write", 32'(ld_en_cnt - en0), 32'd0);
        do_reset();

        // length too large
        en0 = ld_en_cnt;
        send(8'h10); send(8'h01);
        check("e_err", 32'(bus.o_err), 32'd1);
        check("e_ready", 32'(bus.o_ld_ready), 32'd0);
        bus.i_ld_data = 8'h55;
        repeat (100) @(posedge clk);
        #1;
        check("e_err_hold", 32'(bus.o_err), 32'd1);
        check("e_cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
        check("e_done", 32'(bus.o_done), 32'd0);
        check("e_ready_hold", 32'(bus.o_ld_ready), 32'd0);
        check("e_no_write", 32'(ld_en_cnt - en0), 32'd0);
        do_reset();
        check("e_err_cleared", 32'(bus.o_err), 32'd0);

        // reset mid-load, then reload
        send(8'h00); send(8'h01); send(8'h77);
        bus.i_ld_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("m_cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
        check("m_done", 32'(bus.o_done), 32'd0);
        check("m_mem_en", 32'(bus.o_mem_en), 32'd0);
        check("m_ready", 32'(bus.o_ld_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        base = wr_addr.size();
        send(8'h00); send(8'h01); send(8'hCA); send(8'hFE);
        bus.i_ld_valid = 1'b0;
        @(posedge clk); #1;
        check("m_nwr", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() - base == 1) begin
            check("m_addr", wr_addr[base], 32'h0);
            check("m_di", wr_di[base], 32'hCAFE);
        end
        check("m_done_after", 32'(bus.o_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
